mango_bus_target: RTL and testbench

- Memory-mapped bus responder on the Mango2 CPU bus.
- Decodes the CPU's address, write-enable and write-data outputs.
- Serves a 64-byte scratch RAM and a small interval-timer/interrupt register set.
- Returns read data, throttles the CPU through `ready` with programmable wait states, and generates the CPU's `IRQ` and `NMI` inputs.

---
 rtl/mango_bus_target.sv | 105 ++++++++++
 tb/tb_mango_bus_target.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mango_bus_target.sv
// mango_bus_target: Mango2 bus responder with 64-byte scratch RAM, interval timer, IRQ and NMI generation
//   clk, reset (async, active-low)
//   address_bus/data_out/write_enable: CPU address, write data and write strobe
//   data_in: read data (0x00 outside read ACK cycles), ready: low while a selected access waits
//   IRQ: TF & IE level, NMI: 2-cycle pulse on synchronized nmi_btn rising edge
module mango_bus_target #(
   parameter logic [15:0] BASE_ADDR   = 16'hD000,
   parameter int          WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] address_bus,
   input  logic [7:0]  data_out,
   input  logic        write_enable,
   output logic [7:0]  data_in,
   output logic        ready,
   output logic        IRQ,
   output logic        NMI,
   input  logic        nmi_btn
);
   localparam logic [3:0] WS = 4'(WAIT_STATES);
   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
   state_t      state;
   logic [3:0]  cnt;
   logic        sel, ack, wr, rd_ack, tf_set, rise;
   logic [6:0]  off;
   logic        ten, ie, tf, nf;
   logic [15:0] reload, count;
   logic [7:0]  shadow, reg_data;
   logic [2:0]  sync;
   logic [1:0]  pcnt;
   logic [7:0]  ram [64];
   assign sel    = address_bus[15:7] == BASE_ADDR[15:7];
   assign off    = address_bus[6:0];
   assign ack    = sel & ((WS == 4'd0) | (state == ACK));
   assign wr     = ack & write_enable;
   assign rd_ack = ack & !write_enable;
   assign ready  = !sel | (state == ACK);
   assign tf_set = ten & (count == 16'd0);
   assign rise   = sync[1] & !sync[2];
   assign IRQ    = tf & ie;
   assign NMI    = pcnt != 2'd0;
   // cnt holds the ready-low cycles still owed; the IDLE cycle that sees sel is the first of them
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else if (WS == 4'd0) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (sel) begin
               state <= (WS == 4'd1) ? ACK : WAIT;
               cnt   <= WS - 4'd1;
            end
            WAIT: if (!sel) state <= IDLE;
               else if (cnt == 4'd1) state <= ACK;
               else cnt <= cnt - 4'd1;
            default: state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ten    <= 1'b0;
         ie     <= 1'b0;
         reload <= 16'd0;
         count  <= 16'd0;
         tf     <= 1'b0;
         nf     <= 1'b0;
         shadow <= 8'd0;
      end else begin
         if (wr && off == 7'h40) {ie, ten} <= data_out[1:0];
         if (wr && off == 7'h41) reload[7:0] <= data_out;
         if (wr && off == 7'h42) reload[15:8] <= data_out;
         count <= (wr && off == 7'h40 && data_out[0] && !ten) ? reload :
                  !ten ? count : (count == 16'd0) ? reload : count - 16'd1;
         tf <= tf_set | (tf & !(wr && off == 7'h43 && data_out[0]));
         nf <= rise | (nf & !(wr && off == 7'h43 && data_out[1]));
         if (rd_ack && off == 7'h44) shadow <= count[15:8];
      end
   end
   // sync[1:0] is the two-flop synchronizer, sync[2] the previous value for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync <= 3'd0;
         pcnt <= 2'd0;
      end else begin
         sync <= {sync[1:0], nmi_btn};
         pcnt <= rise ? 2'd2 : (pcnt != 2'd0) ? pcnt - 2'd1 : 2'd0;
      end
   end
   always_ff @(posedge clk) begin
      if (wr && reset && !off[6]) ram[off[5:0]] <= data_out;
   end
   always_comb begin
      reg_data = (off == 7'h40) ? {6'd0, ie, ten} :
                 (off == 7'h41) ? reload[7:0] :
                 (off == 7'h42) ? reload[15:8] :
                 (off == 7'h43) ? {6'd0, nf, tf} :
                 (off == 7'h44) ? count[7:0] :
                 (off == 7'h45) ? shadow : 8'h00;
      data_in = !rd_ack ? 8'h00 : off[6] ? reg_data : ram[off[5:0]];
   end
endmodule

// File: tb/tb_mango_bus_target.sv
// tb_mango_bus_target: scoreboard bench for mango_bus_target with WAIT_STATES=1
module tb_mango_bus_target;
   localparam int WS = 1;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] address_bus = 16'hC000;
   logic [7:0]  data_out = 8'h00;
   logic        write_enable = 1'b0;
   logic [7:0]  data_in;
   logic        ready, IRQ, NMI;
   logic        nmi_btn = 1'b0;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q [$];

   mango_bus_target #(.BASE_ADDR(16'hD000), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(reset), .address_bus(address_bus), .data_out(data_out),
      .write_enable(write_enable), .data_in(data_in), .ready(ready),
      .IRQ(IRQ), .NMI(NMI), .nmi_btn(nmi_btn)
   );

   always #5 clk = ~clk;

   // Drives one access starting just after a posedge; returns just after the edge ending ACK.
   task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d, input string nm);
      logic [7:0] exp;
      int lowc;
      bit done;
      address_bus = a;
      write_enable = w;
      data_out = d;
      lowc = 0;
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (ready) begin
            done = 1;
            if (!w) begin
               exp = exp_q.pop_front();
               checks++;
               if (data_in !== exp) begin
                  errors++;
                  $display("FAIL %s: data_in=%h expected %h", nm, data_in, exp);
               end
            end
         end else lowc++;
      end
      checks++;
      if (!done || lowc != WS) begin
         errors++;
         $display("FAIL %s_wait: ready low %0d cycles expected %0d (done=%0d)", nm, lowc, WS, done);
         if (!done && !w) void'(exp_q.pop_front());
      end
      @(posedge clk);
      #1;
      address_bus = 16'hC000;
      write_enable = 1'b0;
      data_out = 8'h00;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d, input string nm);
      access(a, 1'b1, d, nm);
   endtask

   task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string nm);
      exp_q.push_back(exp);
      access(a, 1'b0, 8'h00, nm);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks += 4;
      if (data_in !== 8'h00) begin errors++; $display("FAIL rst_data_in: %h expected 00", data_in); end
      if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready_unsel: %b expected 1", ready); end
      if (IRQ !== 1'b0) begin errors++; $display("FAIL rst_irq: %b expected 0", IRQ); end
      if (NMI !== 1'b0) begin errors++; $display("FAIL rst_nmi: %b expected 0", NMI); end
      address_bus = 16'hD000;
      #1;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready_sel: %b expected 0", ready); end
      address_bus = 16'hC000;
      @(posedge clk);
      #1;
      reset = 1'b1;
      rd(16'hD040, 8'h00, "rst_ctrl");
      rd(16'hD041, 8'h00, "rst_reload_lo");
      rd(16'hD042, 8'h00, "rst_reload_hi");
      rd(16'hD043, 8'h00, "rst_status");
      rd(16'hD044, 8'h00, "rst_count_lo");
      rd(16'hD045, 8'h00, "rst_count_hi");
   endtask

   task automatic test_ram;
      wr(16'hD010, 8'hA5, "ram_wr");
      rd(16'hD010, 8'hA5, "ram_rd");
   endtask

   task automatic test_back_to_back;
      logic [7:0] offs [4] = '{8'h00, 8'h15, 8'h2A, 8'h3F};
      for (int i = 0; i < 4; i++) wr(16'hD000 + 16'(offs[i]), 8'h30 + 8'(i * 17), "b2b_wr");
      for (int i = 0; i < 4; i++) rd(16'hD000 + 16'(offs[i]), 8'h30 + 8'(i * 17), "b2b_rd");
      wr(16'hD015, 8'h5A, "b2b_same_wr");
      rd(16'hD015, 8'h5A, "b2b_same_rd");
   endtask

   task automatic test_unselected;
      address_bus = 16'hC000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks += 2;
         if (ready !== 1'b1) begin errors++; $display("FAIL unsel_ready: %b expected 1", ready); end
         if (data_in !== 8'h00) begin errors++; $display("FAIL unsel_data_in: %h expected 00", data_in); end
      end
      @(posedge clk);
      #1;
      rd(16'hD010, 8'hA5, "unsel_ram_kept");
      wr(16'hD046, 8'hFF, "rsvd_wr");
      rd(16'hD046, 8'h00, "rsvd_rd");
      rd(16'hD07F, 8'h00, "rsvd_top_rd");
   endtask

   task automatic test_timer_irq;
      wr(16'hD041, 8'h03, "tmr_reload_lo");
      wr(16'hD042, 8'h00, "tmr_reload_hi");
      wr(16'hD040, 8'h03, "tmr_ctrl");
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         checks++;
         if (IRQ !== (i == 5)) begin errors++; $display("FAIL irq_rise_%0d: %b expected %b", i, IRQ, i == 5); end
      end
      @(posedge clk);
      #1;
      wr(16'hD043, 8'h01, "tmr_w1c");
      @(negedge clk);
      checks++;
      if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_cleared: %b expected 0", IRQ); end
      @(negedge clk);
      checks++;
      if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_second_period: %b expected 1", IRQ); end
      repeat (2) @(posedge clk);
      #1;
      wr(16'hD043, 8'h01, "tmr_w1c_collide");
      @(negedge clk);
      checks++;
      if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_set_wins: %b expected 1", IRQ); end
      @(posedge clk);
      #1;
      wr(16'hD040, 8'h00, "tmr_stop");
      wr(16'hD043, 8'h01, "tmr_clear");
      rd(16'hD043, 8'h00, "tmr_status_clear");
      rd(16'hD041, 8'h03, "tmr_reload_rd");
   endtask

   task automatic test_count_shadow;
      wr(16'hD041, 8'h35, "cnt_reload_lo");
      wr(16'hD042, 8'h12, "cnt_reload_hi");
      wr(16'hD040, 8'h01, "cnt_start");
      rd(16'hD044, 8'h34, "cnt_lo");
      repeat (300) @(posedge clk);
      #1;
      rd(16'hD045, 8'h12, "cnt_hi_shadow");
      rd(16'hD040, 8'h01, "cnt_ctrl_rd");
      wr(16'hD040, 8'h00, "cnt_stop");
      wr(16'hD043, 8'h03, "cnt_clear");
   endtask

   task automatic test_nmi;
      nmi_btn = 1'b1;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         checks++;
         if (NMI !== (n == 3 || n == 4)) begin
            errors++;
            $display("FAIL nmi_pulse_%0d: %b expected %b", n, NMI, n == 3 || n == 4);
         end
         if (n == 5) nmi_btn = 1'b0;
      end
      @(posedge clk);
      #1;
      rd(16'hD043, 8'h02, "nmi_status");
      rd(16'hD043, 8'h02, "nmi_status_held");
      wr(16'hD043, 8'h02, "nmi_w1c");
      rd(16'hD043, 8'h00, "nmi_status_clear");
   endtask

   task automatic test_reset_mid_access;
      wr(16'hD020, 8'h11, "rma_ram_wr");
      wr(16'hD041, 8'h00, "rma_reload_lo");
      wr(16'hD042, 8'h00, "rma_reload_hi");
      wr(16'hD040, 8'h03, "rma_ctrl");
      repeat (2) @(negedge clk);
      checks++;
      if (IRQ !== 1'b1) begin errors++; $display("FAIL rma_irq_before: %b expected 1", IRQ); end
      @(posedge clk);
      #1;
      address_bus = 16'hD020;
      write_enable = 1'b1;
      data_out = 8'h22;
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL rma_wait: ready=%b expected 0", ready); end
      reset = 1'b0;
      #1;
      checks += 2;
      if (IRQ !== 1'b0) begin errors++; $display("FAIL rma_irq: %b expected 0", IRQ); end
      if (NMI !== 1'b0) begin errors++; $display("FAIL rma_nmi: %b expected 0", NMI); end
      @(posedge clk);
      #1;
      address_bus = 16'hC000;
      write_enable = 1'b0;
      data_out = 8'h00;
      reset = 1'b1;
      rd(16'hD040, 8'h00, "rma_ctrl_rd");
      rd(16'hD020, 8'h11, "rma_ram_kept");
      rd(16'hD043, 8'h00, "rma_status");
   endtask

   initial begin
      test_reset;
      test_ram;
      test_back_to_back;
      test_unselected;
      test_timer_irq;
      test_count_shadow;
      test_nmi;
      test_reset_mid_access;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
